counter_mod_updown: RTL and testbench

//  Parametrised modulo-M up/down counter with clock enable, synchronous load and

---
 rtl/counter_mod_updown_pkg.sv | 25 ++
 rtl/counter_mod_updown_add_cin_cout.sv | 23 ++
 rtl/counter_mod_updown.sv | 84 ++++++++
 tb/tb_counter_mod_updown.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_mod_updown_pkg.sv
// Shared types and helpers for the modulo-M up/down counter.
// Per-edge actions are ordered by priority: reset, then load, then count.
package counter_mod_updown_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    ACT_IDLE,
    ACT_RESET,
    ACT_LOAD,
    ACT_COUNT
  } act_e;

  function automatic act_e decode_act(input logic reset, input logic load, input logic ce);
    if (reset) return ACT_RESET;
    if (load)  return ACT_LOAD;
    if (ce)    return ACT_COUNT;
    return ACT_IDLE;
  endfunction

  function automatic longint full_modulus(input int width);
    return longint'(1) << width;
  endfunction

endpackage

// File: rtl/counter_mod_updown_add_cin_cout.sv
// Ripple-carry adder built from per-bit full-adder cells, with carry in and carry out.
module add_cin_cout #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/counter_mod_updown.sv
// Modulo-M up/down counter with count enable, saturating synchronous load,
// zero-latency terminal-count output and a sticky overflow flag.
module counter_mod_updown
  import counter_mod_updown_pkg::*;
#(
  parameter int     WIDTH       = 2,
  parameter longint MODULUS     = full_modulus(WIDTH),
  parameter longint RESET_VALUE = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DATA,
  input  logic             CLR_OVF,
  output logic [WIDTH-1:0] O,
  output logic             COUT,
  output logic             OVF
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("counter_mod_updown: WIDTH %0d outside 1..%0d", WIDTH, MAX_WIDTH);
  end
  if (MODULUS < 2 || MODULUS > full_modulus(WIDTH)) begin : g_bad_modulus
    $error("counter_mod_updown: MODULUS %0d outside 2..2**WIDTH", MODULUS);
  end
  if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_reset_value
    $error("counter_mod_updown: RESET_VALUE %0d not below MODULUS", RESET_VALUE);
  end

  localparam bit             FULL  = (MODULUS == full_modulus(WIDTH));
  localparam logic [WIDTH-1:0] MAX   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_O = WIDTH'(RESET_VALUE);

  act_e             act;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] sum;
  logic             add_co;
  logic             term;
  logic [WIDTH-1:0] next_o;
  logic [WIDTH-1:0] load_val;
  logic [63:0]      data_ext;

  assign act = decode_act(RESET, LOAD, CE);

  // Increment is O + 0 with carry in; decrement is O + all-ones without it.
  assign operand = {WIDTH{~UP}};

  add_cin_cout #(.WIDTH(WIDTH)) u_add (
    .a    (O),
    .b    (operand),
    .cin  (UP),
    .sum  (sum),
    .cout (add_co)
  );

  // At full modulus the adder carry already marks the wrap in either direction.
  always_comb begin
    term = 1'b0;
    if (UP) term = FULL ? add_co  : (O == MAX);
    else    term = FULL ? ~add_co : (O == '0);
  end

  assign next_o   = term ? (UP ? '0 : MAX) : sum;
  assign data_ext = 64'(DATA);
  assign load_val = (data_ext < 64'(MODULUS)) ? DATA : MAX;
  assign COUT     = (act == ACT_COUNT) & term;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      O   <= RST_O;
      OVF <= 1'b0;
    end else begin
      case (act)
        ACT_LOAD:  O <= load_val;
        ACT_COUNT: O <= next_o;
        default:   O <= O;
      endcase
      OVF <= COUT | (OVF & ~CLR_OVF);
    end
  end

endmodule

// File: tb/tb_counter_mod_updown.sv
// Bench for counter_mod_updown: a full-modulus 2-bit counter and a mod-10 counter
// with reset value 3 share one stimulus bus and are each tracked by an arithmetic model.
module tb_counter_mod_updown;

  localparam int MA = 4;
  localparam int RVA = 0;
  localparam int MB = 10;
  localparam int RVB = 3;

  logic       clk = 1'b0;
  logic       in_reset = 1'b0, in_ce = 1'b0, in_up = 1'b0, in_load = 1'b0, in_clr = 1'b0;
  logic [3:0] in_data = '0;
  logic [1:0] o_a;
  logic [3:0] o_b;
  logic       cout_a, cout_b, ovf_a, ovf_b;

  int n_cmp = 0;
  int n_bad = 0;
  int ma_o = 0, mb_o = 0;
  bit ma_ovf = 1'b0, mb_ovf = 1'b0;
  bit ea_cout, eb_cout;

  always #5 clk = ~clk;

  counter_mod_updown #(.WIDTH(2)) dut_a (
    .CLK(clk), .RESET(in_reset), .CE(in_ce), .UP(in_up), .LOAD(in_load),
    .DATA(in_data[1:0]), .CLR_OVF(in_clr), .O(o_a), .COUT(cout_a), .OVF(ovf_a)
  );

  counter_mod_updown #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(3)) dut_b (
    .CLK(clk), .RESET(in_reset), .CE(in_ce), .UP(in_up), .LOAD(in_load),
    .DATA(in_data), .CLR_OVF(in_clr), .O(o_b), .COUT(cout_b), .OVF(ovf_b)
  );

  function automatic bit model_cout(input int o, input int m);
    if (in_reset || in_load || !in_ce) return 1'b0;
    return in_up ? (o == m - 1) : (o == 0);
  endfunction

  function automatic void model_step(inout int o, inout bit ovf, input int m, input int rv,
                                     input bit c, input int d);
    if (in_reset) begin
      o = rv;
      ovf = 1'b0;
    end else begin
      if (in_load)    o = (d < m) ? d : m - 1;
      else if (in_ce) o = in_up ? (o + 1) % m : (o + m - 1) % m;
      ovf = c | (ovf & !in_clr);
    end
  endfunction

  task automatic apply(input bit r, input bit ce, input bit up, input bit ld, input int d,
                       input bit clr);
    @(negedge clk);
    in_reset = r; in_ce = ce; in_up = up; in_load = ld; in_clr = clr; in_data = 4'(d);
    #1;
    ea_cout = model_cout(ma_o, MA);
    eb_cout = model_cout(mb_o, MB);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(ma_o, ma_ovf, MA, RVA, ea_cout, int'(in_data) % MA);
    model_step(mb_o, mb_ovf, MB, RVB, eb_cout, int'(in_data));
    #1;
  endtask

  task automatic test_reset();
    apply(1, 1, 1, 1, 7, 0);
    n_cmp++; if (cout_b !== 1'b0) begin n_bad++; $display("FAIL reset_cout_b: got %b want 0", cout_b); end
    tick();
    n_cmp++; if (o_a !== 2'd0) begin n_bad++; $display("FAIL reset_o_a: got %0d want 0", o_a); end
    n_cmp++; if (o_b !== 4'd3) begin n_bad++; $display("FAIL reset_o_b: got %0d want 3", o_b); end
    n_cmp++; if (ovf_a !== 1'b0 || ovf_b !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b%b want 00", ovf_a, ovf_b); end
  endtask

  task automatic test_count_up();
    int prev[5] = '{0, 1, 2, 3, 0};
    int seq[5]  = '{1, 2, 3, 0, 1};
    apply(1, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      apply(0, 1, 1, 0, 0, 0);
      n_cmp++;
      if (cout_a !== (prev[i] == 3)) begin n_bad++; $display("FAIL up_cout_a[%0d]: got %b want %b", i, cout_a, prev[i] == 3); end
      tick();
      n_cmp++;
      if (o_a !== 2'(seq[i])) begin n_bad++; $display("FAIL up_o_a[%0d]: got %0d want %0d", i, o_a, seq[i]); end
      n_cmp++;
      if (ovf_a !== (i >= 3)) begin n_bad++; $display("FAIL up_ovf_a[%0d]: got %b want %b", i, ovf_a, i >= 3); end
    end
  endtask

  task automatic test_count_down();
    int exp = 3;
    apply(1, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 14; i++) begin
      apply(0, 1, 0, 0, 0, 0);
      n_cmp++;
      if (cout_b !== (exp == 0)) begin n_bad++; $display("FAIL down_cout_b[%0d]: got %b want %b", i, cout_b, exp == 0); end
      tick();
      exp = (exp == 0) ? 9 : exp - 1;
      n_cmp++;
      if (o_b !== 4'(exp) || o_b >= 4'd10) begin n_bad++; $display("FAIL down_o_b[%0d]: got %0d want %0d", i, o_b, exp); end
    end
  endtask

  task automatic test_load();
    apply(0, 0, 0, 0, 0, 1);
    tick();
    apply(0, 0, 0, 1, 7, 0);
    tick();
    n_cmp++; if (o_b !== 4'd7) begin n_bad++; $display("FAIL load7_o_b: got %0d want 7", o_b); end
    apply(0, 0, 0, 1, 12, 0);
    tick();
    n_cmp++; if (o_b !== 4'd9) begin n_bad++; $display("FAIL load12_sat_o_b: got %0d want 9", o_b); end
    apply(0, 1, 1, 1, 4, 0);
    n_cmp++; if (cout_b !== 1'b0) begin n_bad++; $display("FAIL load_ce_cout_b: got %b want 0", cout_b); end
    tick();
    n_cmp++; if (o_b !== 4'd4) begin n_bad++; $display("FAIL load_ce_o_b: got %0d want 4", o_b); end
    n_cmp++; if (ovf_b !== 1'b0) begin n_bad++; $display("FAIL load_ce_ovf_b: got %b want 0", ovf_b); end
  endtask

  task automatic test_hold_toggle();
    int seq[4] = '{6, 5, 6, 5};
    apply(0, 0, 0, 1, 5, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 1'($urandom_range(0, 1)), 0, 0, 0);
      n_cmp++; if (cout_b !== 1'b0) begin n_bad++; $display("FAIL hold_cout_b[%0d]: got %b want 0", i, cout_b); end
      tick();
      n_cmp++; if (o_b !== 4'd5) begin n_bad++; $display("FAIL hold_o_b[%0d]: got %0d want 5", i, o_b); end
    end
    for (int i = 0; i < 4; i++) begin
      apply(0, 1, (i % 2 == 0), 0, 0, 0);
      tick();
      n_cmp++;
      if (o_b !== 4'(seq[i])) begin n_bad++; $display("FAIL toggle_o_b[%0d]: got %0d want %0d", i, o_b, seq[i]); end
    end
  endtask

  task automatic test_ovf_clear();
    apply(0, 0, 0, 0, 0, 1);
    tick();
    n_cmp++; if (ovf_b !== 1'b0) begin n_bad++; $display("FAIL clr_ovf_b: got %b want 0", ovf_b); end
    for (int k = 0; k < 2; k++) begin
      apply(0, 0, 0, 1, 9, 0);
      tick();
      apply(0, 1, 1, 0, 0, 1);
      n_cmp++; if (cout_b !== 1'b1) begin n_bad++; $display("FAIL wrap_cout_b[%0d]: got %b want 1", k, cout_b); end
      tick();
      n_cmp++; if (o_b !== 4'd0 || ovf_b !== 1'b1) begin n_bad++; $display("FAIL wrap_clr_b[%0d]: got o=%0d ovf=%b want o=0 ovf=1", k, o_b, ovf_b); end
    end
    apply(0, 0, 0, 0, 0, 1);
    tick();
    n_cmp++; if (ovf_b !== 1'b0 || o_b !== 4'd0) begin n_bad++; $display("FAIL clr_alone_b: got o=%0d ovf=%b want o=0 ovf=0", o_b, ovf_b); end
  endtask

  task automatic test_reset_priority();
    apply(0, 0, 0, 1, 9, 0);
    tick();
    apply(0, 1, 1, 0, 0, 0);
    tick();
    apply(0, 0, 0, 1, 9, 0);
    tick();
    n_cmp++; if (ovf_b !== 1'b1 || o_b !== 4'd9) begin n_bad++; $display("FAIL prio_setup_b: got o=%0d ovf=%b want o=9 ovf=1", o_b, ovf_b); end
    apply(1, 1, 1, 1, 5, 0);
    n_cmp++; if (cout_b !== 1'b0) begin n_bad++; $display("FAIL prio_cout_b: got %b want 0", cout_b); end
    tick();
    n_cmp++; if (o_b !== 4'd3 || ovf_b !== 1'b0) begin n_bad++; $display("FAIL prio_b: got o=%0d ovf=%b want o=3 ovf=0", o_b, ovf_b); end
    n_cmp++; if (o_a !== 2'd0 || ovf_a !== 1'b0) begin n_bad++; $display("FAIL prio_a: got o=%0d ovf=%b want o=0 ovf=0", o_a, ovf_a); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      apply(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0));
      n_cmp++; if (cout_a !== ea_cout) begin n_bad++; $display("FAIL rnd_cout_a[%0d]: got %b want %b", i, cout_a, ea_cout); end
      n_cmp++; if (cout_b !== eb_cout) begin n_bad++; $display("FAIL rnd_cout_b[%0d]: got %b want %b", i, cout_b, eb_cout); end
      tick();
      n_cmp++; if (o_a !== 2'(ma_o)) begin n_bad++; $display("FAIL rnd_o_a[%0d]: got %0d want %0d", i, o_a, ma_o); end
      n_cmp++; if (o_b !== 4'(mb_o)) begin n_bad++; $display("FAIL rnd_o_b[%0d]: got %0d want %0d", i, o_b, mb_o); end
      n_cmp++; if (ovf_a !== ma_ovf) begin n_bad++; $display("FAIL rnd_ovf_a[%0d]: got %b want %b", i, ovf_a, ma_ovf); end
      n_cmp++; if (ovf_b !== mb_ovf) begin n_bad++; $display("FAIL rnd_ovf_b[%0d]: got %b want %b", i, ovf_b, mb_ovf); end
      n_cmp++; if (o_b >= 4'd10) begin n_bad++; $display("FAIL rnd_range_b[%0d]: got %0d want <10", i, o_b); end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_hold_toggle();
    test_ovf_clear();
    test_reset_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
